// File: rtl/mem2axis_pkg.sv
// Shared types and constants for the frame-buffer readout stage.
package mem2axis_pkg;
  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/axis_if.sv
// AXI-Stream style bundle: data/last qualified by vld, beat transfers on vld && rdy.
interface axis_if #(parameter int DW = 32);
  logic [DW-1:0] data;
  logic          vld;
  logic          last;
  logic          rdy;

  modport out (output data, vld, last, input rdy);
  modport in  (input data, vld, last, output rdy);
endinterface

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO for {last, data} stream words; caller never pushes when full
// (after this cycle's pop) and never pops when empty.
module axis_skid_fifo
  import mem2axis_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 push_i,
  input  logic [W-1:0]         push_data_i,
  input  logic                 pop_i,
  output logic [W-1:0]         head_o,
  output logic [BUF_CNT_W-1:0] count_o
);
  logic [W-1:0]         mem_q [BUF_DEPTH];
  logic                 wptr_q;
  logic                 rptr_q;
  logic [BUF_CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) rptr_q <= ~rptr_q;
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + BUF_CNT_W'(1);
        2'b01:   count_q <= count_q - BUF_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/mem2axis.sv
// Frame readout: streams words 0..len from a synchronous-read memory onto an
// AXI-Stream output, with reads paced by credits into a 2-entry buffer.
module mem2axis
  import mem2axis_pkg::*;
#(
  parameter int DW     = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len_m1,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DW-1:0]     mem_rdata,
  axis_if.out               stream_out,
  output state_t            dbg_state
);
  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(DEPTH - 1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    len_lat_q, len_lat_d;
  logic [ADDR_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;
  logic                 done_q, done_d;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 issue;
  logic                 pop;
  logic                 vld;
  logic [DW:0]          head;
  logic [BUF_CNT_W-1:0] count;
  logic [BUF_CNT_W-1:0] occ_after;

  // Handshake: a beat transfers on the rising edge where vld && rdy; once vld
  // rises, data/last hold until that transfer (buffer head only moves on pop).
  assign vld = (count != '0);
  assign pop = vld && stream_out.rdy;

  // Credit check counts words buffered plus the read still in flight.
  assign occ_after = count - BUF_CNT_W'(pop) + BUF_CNT_W'(inflight_q);
  assign issue     = (state_q == RUN) && (occ_after < BUF_CNT_W'(BUF_DEPTH));

  always_comb begin
    state_d   = state_q;
    len_lat_d = len_lat_q;
    rd_cnt_d  = rd_cnt_q;
    raddr_d   = raddr_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          len_lat_d = (len_m1 > LEN_MAX) ? LEN_MAX : len_m1;
          rd_cnt_d  = '0;
        end
      end
      RUN: begin
        if (issue) begin
          raddr_d = rd_cnt_q;
          if (rd_cnt_q == len_lat_q) state_d = DRAIN;
          else rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (pop && head[DW]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q         <= IDLE;
      len_lat_q       <= '0;
      rd_cnt_q        <= '0;
      raddr_q         <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_lat_q       <= len_lat_d;
      rd_cnt_q        <= rd_cnt_d;
      raddr_q         <= raddr_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_cnt_q == len_lat_q);
    end
  end

  axis_skid_fifo #(.W(DW + 1)) u_fifo (
    .clk         (clk),
    .a_rst       (a_rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, mem_rdata}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign mem_ren         = issue;
  assign mem_raddr       = issue ? rd_cnt_q : raddr_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign stream_out.vld  = vld;
  assign stream_out.data = head[DW-1:0];
  assign stream_out.last = head[DW] && vld;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_mem2axis.sv
// Directed bench for mem2axis: frame memory model, per-cycle scoreboard on the
// output stream, latency/done/busy timing checks and a mid-frame reset.
module tb_mem2axis;
  import mem2axis_pkg::*;

  localparam int DW     = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              a_rst;
  logic              start;
  logic [ADDR_W-1:0] len_m1;
  logic              busy;
  logic              done;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DW-1:0]     mem_rdata;
  state_t            dbg_state;

  axis_if #(.DW(DW)) s_if ();

  mem2axis #(.DW(DW), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .start      (start),
    .len_m1     (len_m1),
    .busy       (busy),
    .done       (done),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .stream_out (s_if),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fmem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) fmem[i] = 32'hA0 + i;
    mem_rdata = '0;
  end
  always @(posedge clk) if (mem_ren) mem_rdata <= fmem[mem_raddr[3:0]];

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] rdy_pat = 4'b1001;  // bit c%4: 1,0,0,1

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver: one frame, cycle 0 = cycle start is high ----------------
  task automatic run_frame(input logic [ADDR_W-1:0] len, input int mode, input bit chained,
                           input bit poke_start, input bit chain_next,
                           input logic [ADDR_W-1:0] next_len);
    int n, c, first_vld, last_hs, beats;
    bit fin;
    logic [DW:0] e;
    n = (len > DEPTH - 1) ? DEPTH : int'(len) + 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), fmem[i]});
    first_vld = -1; last_hs = -1; beats = 0; fin = 0;
    c = chained ? 1 : 0;
    while (!fin && c < 300) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0 && !chained) begin start = 1'b1; len_m1 = len; end
      if (poke_start && c == 2) begin start = 1'b1; len_m1 = 10'd9; end
      if (chain_next && last_hs >= 0 && c == last_hs + 1) begin start = 1'b1; len_m1 = next_len; end
      s_if.rdy = (mode == 0) ? 1'b1 : rdy_pat[c % 4];
      #1;
      if (c == 1) begin
        check("ren_c1", mem_ren, 1);
        check("raddr_c1", mem_raddr, 0);
      end
      if (c == 2) begin
        check("ren_c2", mem_ren, (n > 1));
        check("raddr_c2", mem_raddr, (n > 1) ? 1 : 0);
      end
      if (c >= 1 && c < 3) check("vld_early", s_if.vld, 0);
      if (s_if.vld && first_vld < 0) begin
        first_vld = c;
        check("first_vld_cyc", 64'(c), 64'(3));
      end
      if (s_if.vld && !s_if.rdy) check("occ_le2", 64'(dut.u_fifo.count_o <= 2), 1);
      if (s_if.vld) begin
        if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'(1));
        else begin
          e = exp_q[0];
          check("beat_data", s_if.data, e[DW-1:0]);
          check("beat_last", s_if.last, e[DW]);
          if (s_if.rdy) begin
            if (mode == 0) check("beat_cyc", 64'(c), 64'(3 + beats));
            void'(exp_q.pop_front());
            beats++;
            if (e[DW]) last_hs = c;
          end
        end
      end
      if (done) begin
        fin = 1;
        check("done_cyc", 64'(c), 64'(last_hs + 1));
        check("busy_at_done", busy, 0);
        check("beats", 64'(beats), 64'(n));
        check("exp_left", 64'(exp_q.size()), 0);
      end else if (c >= 1) begin
        check("busy_run", busy, 1);
      end
      c++;
    end
    check("done_seen", fin, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    a_rst = 1'b1; start = 1'b0; len_m1 = '0; s_if.rdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_vld", s_if.vld, 0);
    check("rst_last", s_if.last, 0);
    check("rst_data", s_if.data, 0);
    @(negedge clk);
    a_rst = 1'b0;

    run_frame(10'd3, 0, 0, 0, 0, '0);   // basic 4-beat frame
    run_frame(10'd0, 0, 0, 0, 0, '0);   // single beat
    run_frame(10'd7, 1, 0, 0, 0, '0);   // rdy 1,0,0,1 backpressure
    run_frame(10'd20, 0, 0, 0, 0, '0);  // clamped to 16 beats

    // reset on the 3rd beat of a 10-beat frame
    @(negedge clk); start = 1'b1; len_m1 = 10'd9; s_if.rdy = 1'b1;
    for (int c = 1; c <= 5; c++) begin @(negedge clk); start = 1'b0; end
    #1;
    check("abort_pre_vld", s_if.vld, 1);
    check("abort_pre_data", s_if.data, 32'hA2);
    a_rst = 1'b1;
    #1;
    check("abort_vld", s_if.vld, 0);
    check("abort_busy", busy, 0);
    check("abort_ren", mem_ren, 0);
    @(negedge clk); a_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("abort_no_done", done, 0);
      check("abort_idle_vld", s_if.vld, 0);
    end
    run_frame(10'd1, 0, 0, 0, 0, '0);   // clean 2-beat frame after abort

    // start ignored in RUN, then restart on the done cycle
    run_frame(10'd3, 0, 0, 1, 1, 10'd2);
    run_frame(10'd2, 0, 1, 0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
